bf16_dot_acc_44: RTL and testbench
==================================

Name: bf16_dot_acc_44

Overview:
Streaming BF16 multiply-accumulate engine. It computes a signed dot product over a variable-length vector of BF16 operand pairs, delimited by a last flag, and returns one BF16 result per vector. It is the successor to the standalone BF16 multiplier/adder pair: it fuses both into a stallable two-stage pipeline. It adds a wider internal accumulator, per-element add/subtract, valid/ready handshakes on both sides, exception flags and an element count. It sits between operand-fetch logic and the result writeback path of the inference datapath.

Parameters:
ACC_MANT_W, 23, accumulator mantissa width (7..23); 23 gives FP32-precision accumulation.
CNT_W, 8, width of the element counter; the count saturates at 2^CNT_W-1.

Ports:
clk_44  in  1  clock, rising edge
rst_44  in  1  asynchronous active-high reset
in_a_44  in  16  BF16 operand A
in_b_44  in  16  BF16 operand B
in_sub_44  in  1  1: accumulator -= A*B; 0: accumulator += A*B
in_last_44  in  1  final element of the vector
in_valid_44  in  1  input beat valid
in_ready_44  out  1  input beat accepted when valid&&ready
out_result_44  out  16  BF16 dot-product result
out_count_44  out  CNT_W  elements in the vector (saturating)
out_special_44  out  1  NaN/Inf seen on an input in the vector
out_ovf_44  out  1  accumulator overflowed, result saturated
out_valid_44  out  1  result valid; held until out_ready_44
out_ready_44  in  1  downstream accepts the result

Behaviour:
- Reset (async, any time, including mid-vector):
  - all outputs 0; accumulator 0; stages S1/S2 empty; count 0; sticky flags 0.
  - A partial vector is discarded.
- Pipeline enable: pipe_en = !out_valid_44 || out_ready_44.
  - in_ready_44 = pipe_en.
  - When pipe_en=0, every stage holds its value.
- S1, registered on acceptance: BF16 product, flush-to-zero semantics.
  - If either input exponent is 00, the product is +0.
  - Product exponent = eA+eB-127.
  - The 8x8-bit mantissa product is normalised; the unbiased product keeps 16 bits.
  - The sign is sA^sB^in_sub_44.
  - If either exponent is FF, the special bit is set.
- S2 accumulate: align the smaller operand, shifting right with truncation.
  - Add or subtract the magnitudes, then renormalise to ACC_MANT_W with round-toward-zero.
  - If the accumulator exponent reaches >=255, the value saturates to ±max and the ovf sticky bit sets.
  - Exponent <=0 flushes to +0.
  - An exact-zero result is +0.
- Last element in S2 (same edge):
  - out_result_44 = accumulator-with-that-element, truncated to BF16.
  - out_count_44, out_special_44 and out_ovf_44 are loaded.
  - out_valid_44 is set.
  - The accumulator, count and stickies clear for the next vector.
- Result priority: special → 16'h7FC0; else ovf → 16'h7F80/16'hFF80 by sign; else the truncated value.
- Latency: last beat accepted at edge N → out_valid_44 high after edge N+2, assuming no stall.
  - Throughput is 1 beat/cycle.
  - Back-to-back length-1 vectors give consecutive results.
- out_valid_44 clears on out_valid&&out_ready unless a new result loads on the same edge; in that case it stays high with the new data.
- in_valid_44 low creates bubbles in S1/S2. Bubbles do not touch the accumulator.

Decomposition:
- Package bf16_pkg_44 holds:
  - BF16 field widths and bias (127);
  - constants QNAN=16'h7FC0, PINF=16'h7F80, NINF=16'hFF80;
  - a function to unpack BF16 into sign/exp/mant.
- One sub-module: bf16_acc_align_add_44. It is the combinational S2 align/add/normalise, parametrised by ACC_MANT_W.
- The top level holds the S1 multiply, the handshake/stall logic and the output register.

Test Plan:
- Single beat A=0x3DCC, B=0x3E80, last=1, out_ready=1 → 2 cycles later out_result=0x3CCC, count=1, flags 0.
- Four beats 0x3F80*0x3F80, last on the 4th → 0x4080 (4.0), count=4. Then sub beats 0x4000*0x4040 add and 0x3F80*0x3F80 sub → 0x40A0 (5.0).
- Backpressure: hold out_ready=0 while a result is pending → in_ready=0, S1/S2 and the result frozen. Release → next result follows on the next cycle; no beat is lost or duplicated.
- Specials: 0x7F80*0x0000 in a 3-beat vector → 0x7FC0, special=1. 0x7F00*0x7F00, last → 0x7F80, ovf=1, special=0.
- Reset mid-vector: after 2 beats assert rst_44 asynchronously between edges → all outputs 0 immediately. A fresh 1-beat vector 0x4000*0x3F80 → 0x4000, count=1.
- Random regression: 1000 vectors of length 1..40 versus a real-valued model with truncation; error ≤ 1 BF16 ulp. A 300-beat vector with CNT_W=8 → count=255.

Source files
------------

// File: rtl/bf16_pkg_44.sv
// Shared BF16 field layout, special encodings and the product record that
// travels through the S1/S2 pipeline of the dot-product engine.
package bf16_pkg_44;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 7;
  localparam int BIAS   = 127;
  localparam int PEXP_W = 11;

  localparam logic [15:0] QNAN = 16'h7FC0;
  localparam logic [15:0] PINF = 16'h7F80;
  localparam logic [15:0] NINF = 16'hFF80;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  expo;
    logic [FRAC_W-1:0] frac;
  } bf16_t;

  // Normalised product: leading one sits at mant[15], expo is biased and may
  // fall outside 1..254 before the accumulator clamps it.
  typedef struct packed {
    logic                     valid;
    logic                     last;
    logic                     special;
    logic                     zero;
    logic                     sign;
    logic signed [PEXP_W-1:0] expo;
    logic [15:0]              mant;
  } prod_t;

  function automatic bf16_t bf16_unpack(input logic [15:0] v);
    bf16_t f;
    f.sign = v[15];
    f.expo = v[14:7];
    f.frac = v[6:0];
    return f;
  endfunction

endpackage

// File: rtl/bf16_acc_align_add_44.sv
// Combinational accumulate step: align the smaller magnitude (truncating),
// add or subtract, renormalise to ACC_MANT_W bits, then clamp the exponent.
module bf16_acc_align_add_44
  import bf16_pkg_44::*;
#(
  parameter int ACC_MANT_W = 23
) (
  input  logic                     acc_sign,
  input  logic [EXP_W-1:0]         acc_expo,
  input  logic [ACC_MANT_W:0]      acc_mant,
  input  logic                     p_sign,
  input  logic                     p_zero,
  input  logic signed [PEXP_W-1:0] p_expo,
  input  logic [15:0]              p_mant,
  output logic                     res_sign,
  output logic [EXP_W-1:0]         res_expo,
  output logic [ACC_MANT_W:0]      res_mant,
  output logic                     res_ovf
);

  localparam int M = ACC_MANT_W + 1;
  localparam int F = (M > 16) ? M : 16;

  logic [F-1:0] a_mag, b_mag, big_mag, small_mag, aligned, norm;
  logic [F:0]   sum;
  logic         a_zero, a_big, big_sign;
  int           big_expo, small_expo, sh, lead, res_expo_i;

  always_comb begin
    // NOTE: every variable gets a value before any branch, so no path can
    // leave one unassigned and infer a latch.
    a_mag             = '0;
    b_mag             = '0;
    a_mag[F-1 -: M]   = acc_mant;
    b_mag[F-1 -: 16]  = p_mant;
    // An accumulator exponent of 0 encodes an exact zero.
    a_zero = (acc_expo == '0);
    if (a_zero) a_mag = '0;
    if (p_zero) b_mag = '0;

    if (a_zero)      a_big = 1'b0;
    else if (p_zero) a_big = 1'b1;
    else             a_big = (int'(acc_expo) > int'(p_expo)) ||
                             ((int'(acc_expo) == int'(p_expo)) && (a_mag >= b_mag));

    big_mag    = a_big ? a_mag : b_mag;
    small_mag  = a_big ? b_mag : a_mag;
    big_sign   = a_big ? acc_sign : p_sign;
    big_expo   = a_big ? int'(acc_expo) : int'(p_expo);
    small_expo = a_big ? int'(p_expo) : int'(acc_expo);
    sh         = big_expo - small_expo;
    aligned    = (sh >= 0 && sh < F) ? small_mag >> sh : '0;

    if (acc_sign == p_sign) sum = {1'b0, big_mag} + {1'b0, aligned};
    else                    sum = {1'b0, big_mag} - {1'b0, aligned};

    lead = 0;
    for (int i = 0; i <= F; i++) begin
      if (sum[i]) lead = i;
    end
    if (lead == F) begin
      norm       = F'(sum >> 1);
      res_expo_i = big_expo + 1;
    end else begin
      norm       = F'(sum << (F - 1 - lead));
      res_expo_i = big_expo - (F - 1 - lead);
    end

    res_sign = big_sign;
    res_expo = EXP_W'(res_expo_i);
    res_mant = norm[F-1 -: M];
    res_ovf  = 1'b0;
    if (sum == '0 || res_expo_i <= 0) begin
      res_sign = 1'b0;
      res_expo = '0;
      res_mant = '0;
    end else if (res_expo_i >= 255) begin
      res_expo = 8'hFE;
      res_mant = '1;
      res_ovf  = 1'b1;
    end
  end

endmodule

// File: rtl/bf16_dot_acc_44.sv
// Streaming BF16 dot-product engine: S1 multiply, S2 feeds the accumulator,
// and the last element of a vector loads the held output register.
module bf16_dot_acc_44
  import bf16_pkg_44::*;
#(
  parameter int ACC_MANT_W = 23,
  parameter int CNT_W      = 8
) (
  input  logic             clk_44,
  input  logic             rst_44,
  input  logic [15:0]      in_a_44,
  input  logic [15:0]      in_b_44,
  input  logic             in_sub_44,
  input  logic             in_last_44,
  input  logic             in_valid_44,
  output logic             in_ready_44,
  output logic [15:0]      out_result_44,
  output logic [CNT_W-1:0] out_count_44,
  output logic             out_special_44,
  output logic             out_ovf_44,
  output logic             out_valid_44,
  input  logic             out_ready_44
);

  localparam int               M       = ACC_MANT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  bf16_t       a_f, b_f;
  logic [15:0] ma, mb, mprod;
  int          p_expo_i;
  prod_t       p_new, s1, s2;
  logic        pipe_en, accept;

  logic             acc_sign, nxt_sign, add_ovf;
  logic [EXP_W-1:0] acc_expo, nxt_expo;
  logic [M-1:0]     acc_mant, nxt_mant;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             spec_st, ovf_st, spec_nxt, ovf_nxt;
  logic [15:0]      result_nxt;

  assign pipe_en     = !out_valid_44 || out_ready_44;
  assign in_ready_44 = pipe_en;
  assign accept      = in_valid_44 && pipe_en;

  always_comb begin
    a_f      = bf16_unpack(in_a_44);
    b_f      = bf16_unpack(in_b_44);
    ma       = {8'h00, 1'b1, a_f.frac};
    mb       = {8'h00, 1'b1, b_f.frac};
    mprod    = ma * mb;
    p_expo_i = int'(a_f.expo) + int'(b_f.expo) - BIAS + (mprod[15] ? 1 : 0);

    p_new         = '0;
    p_new.valid   = accept;
    p_new.last    = in_last_44;
    p_new.special = (a_f.expo == '1) || (b_f.expo == '1);
    p_new.zero    = (a_f.expo == '0) || (b_f.expo == '0);
    p_new.sign    = a_f.sign ^ b_f.sign ^ in_sub_44;
    p_new.expo    = PEXP_W'(p_expo_i);
    p_new.mant    = mprod[15] ? mprod : {mprod[14:0], 1'b0};
  end

  always_ff @(posedge clk_44 or posedge rst_44) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_44) begin
      s1 <= '0;
      s2 <= '0;
    end else if (pipe_en) begin
      s1 <= p_new;
      s2 <= s1;
    end
  end

  bf16_acc_align_add_44 #(.ACC_MANT_W(ACC_MANT_W)) u_add (
    .acc_sign (acc_sign),
    .acc_expo (acc_expo),
    .acc_mant (acc_mant),
    .p_sign   (s2.sign),
    .p_zero   (s2.zero),
    .p_expo   (s2.expo),
    .p_mant   (s2.mant),
    .res_sign (nxt_sign),
    .res_expo (nxt_expo),
    .res_mant (nxt_mant),
    .res_ovf  (add_ovf)
  );

  always_comb begin
    cnt_nxt  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    spec_nxt = spec_st | s2.special;
    ovf_nxt  = ovf_st | add_ovf;
    if (spec_nxt)     result_nxt = QNAN;
    else if (ovf_nxt) result_nxt = nxt_sign ? NINF : PINF;
    else              result_nxt = {nxt_sign, nxt_expo, nxt_mant[M-2 -: FRAC_W]};
  end

  always_ff @(posedge clk_44 or posedge rst_44) begin
    if (rst_44) begin
      acc_sign       <= 1'b0;
      acc_expo       <= '0;
      acc_mant       <= '0;
      cnt            <= '0;
      spec_st        <= 1'b0;
      ovf_st         <= 1'b0;
      out_result_44  <= '0;
      out_count_44   <= '0;
      out_special_44 <= 1'b0;
      out_ovf_44     <= 1'b0;
      out_valid_44   <= 1'b0;
    end else if (pipe_en) begin
      out_valid_44 <= s2.valid && s2.last;
      if (s2.valid && s2.last) begin
        out_result_44  <= result_nxt;
        out_count_44   <= cnt_nxt;
        out_special_44 <= spec_nxt;
        out_ovf_44     <= ovf_nxt;
        acc_sign       <= 1'b0;
        acc_expo       <= '0;
        acc_mant       <= '0;
        cnt            <= '0;
        spec_st        <= 1'b0;
        ovf_st         <= 1'b0;
      end else if (s2.valid) begin
        acc_sign <= nxt_sign;
        acc_expo <= nxt_expo;
        acc_mant <= nxt_mant;
        cnt      <= cnt_nxt;
        spec_st  <= spec_nxt;
        ovf_st   <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bf16_dot_acc_44.sv
// Directed bench for bf16_dot_acc_44: hand-computed BF16 dot products,
// latency, backpressure, specials, overflow, mid-vector reset and saturation.
module tb_bf16_dot_acc_44;

  logic        clk_44, rst_44;
  logic [15:0] in_a_44, in_b_44;
  logic        in_sub_44, in_last_44, in_valid_44, in_ready_44;
  logic [15:0] out_result_44;
  logic [7:0]  out_count_44;
  logic        out_special_44, out_ovf_44, out_valid_44, out_ready_44;

  int n_tests = 0;
  int n_fail  = 0;

  bf16_dot_acc_44 dut (
    .clk_44         (clk_44),
    .rst_44         (rst_44),
    .in_a_44        (in_a_44),
    .in_b_44        (in_b_44),
    .in_sub_44      (in_sub_44),
    .in_last_44     (in_last_44),
    .in_valid_44    (in_valid_44),
    .in_ready_44    (in_ready_44),
    .out_result_44  (out_result_44),
    .out_count_44   (out_count_44),
    .out_special_44 (out_special_44),
    .out_ovf_44     (out_ovf_44),
    .out_valid_44   (out_valid_44),
    .out_ready_44   (out_ready_44)
  );

  initial clk_44 = 1'b0;
  always #5 clk_44 = ~clk_44;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk_44);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic last);
    int guard = 0;
    in_a_44     = a;
    in_b_44     = b;
    in_sub_44   = sub;
    in_last_44  = last;
    in_valid_44 = 1'b1;
    while (!in_ready_44 && guard < 100) begin
      tick();
      guard++;
    end
    if (!in_ready_44) check("send_ready_timeout", 32'(in_ready_44), 32'h1);
    tick();
    in_valid_44 = 1'b0;
    in_last_44  = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [15:0] r, input logic [7:0] c,
                            input logic sp, input logic ov);
    int guard = 0;
    while (!out_valid_44 && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, "_valid"},   32'(out_valid_44),   32'h1);
    check({tag, "_result"},  32'(out_result_44),  32'(r));
    check({tag, "_count"},   32'(out_count_44),   32'(c));
    check({tag, "_special"}, 32'(out_special_44), 32'(sp));
    check({tag, "_ovf"},     32'(out_ovf_44),     32'(ov));
    tick();
  endtask

  initial begin
    rst_44       = 1'b1;
    in_a_44      = '0;
    in_b_44      = '0;
    in_sub_44    = 1'b0;
    in_last_44   = 1'b0;
    in_valid_44  = 1'b0;
    out_ready_44 = 1'b1;
    tick();
    check("rst_valid",   32'(out_valid_44),   32'h0);
    check("rst_result",  32'(out_result_44),  32'h0);
    check("rst_count",   32'(out_count_44),   32'h0);
    check("rst_special", 32'(out_special_44), 32'h0);
    check("rst_ovf",     32'(out_ovf_44),     32'h0);
    rst_44 = 1'b0;
    tick();

    // Single beat with latency check: 0.1 * 0.25
    send(16'h3DCC, 16'h3E80, 1'b0, 1'b1);
    check("lat_e0", 32'(out_valid_44), 32'h0);
    tick();
    check("lat_e1", 32'(out_valid_44), 32'h0);
    tick();
    check("lat_e2", 32'(out_valid_44), 32'h1);
    get_result("single", 16'h3CCC, 8'd1, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) send(16'h3F80, 16'h3F80, 1'b0, i == 3);
    get_result("four_ones", 16'h4080, 8'd4, 1'b0, 1'b0);
    send(16'h4000, 16'h4040, 1'b0, 1'b0);
    send(16'h3F80, 16'h3F80, 1'b1, 1'b1);
    get_result("six_minus_one", 16'h40A0, 8'd2, 1'b0, 1'b0);

    send(16'h3F80, 16'h3F80, 1'b0, 1'b0);
    send(16'h3F80, 16'h3F80, 1'b1, 1'b1);
    get_result("exact_zero", 16'h0000, 8'd2, 1'b0, 1'b0);
    send(16'hBF80, 16'h3F80, 1'b0, 1'b1);
    get_result("neg_product", 16'hBF80, 8'd1, 1'b0, 1'b0);
    send(16'hBF80, 16'h3F80, 1'b1, 1'b1);
    get_result("neg_sub", 16'h3F80, 8'd1, 1'b0, 1'b0);
    send(16'h0080, 16'h3F00, 1'b0, 1'b1);
    get_result("underflow_ftz", 16'h0000, 8'd1, 1'b0, 1'b0);

    // Two 2^-8 terms only survive with a wide accumulator
    send(16'h3F80, 16'h3F80, 1'b0, 1'b0);
    send(16'h3B80, 16'h3F80, 1'b0, 1'b0);
    send(16'h3B80, 16'h3F80, 1'b0, 1'b1);
    get_result("wide_acc", 16'h3F81, 8'd3, 1'b0, 1'b0);

    send(16'h3F80, 16'h4000, 1'b0, 1'b0);
    repeat (3) tick();
    send(16'h3F80, 16'h3F80, 1'b0, 1'b1);
    get_result("bubbles", 16'h4040, 8'd2, 1'b0, 1'b0);

    send(16'h3F80, 16'h3F80, 1'b0, 1'b0);
    send(16'h7F80, 16'h0000, 1'b0, 1'b0);
    send(16'h3F80, 16'h3F80, 1'b0, 1'b1);
    get_result("inf_times_zero", 16'h7FC0, 8'd3, 1'b1, 1'b0);
    send(16'h7F00, 16'h7F00, 1'b0, 1'b1);
    get_result("pos_ovf", 16'h7F80, 8'd1, 1'b0, 1'b1);
    send(16'hFF00, 16'h7F00, 1'b0, 1'b1);
    get_result("neg_ovf", 16'hFF80, 8'd1, 1'b0, 1'b1);
    send(16'h4000, 16'h3F80, 1'b0, 1'b1);
    get_result("ovf_cleared", 16'h4000, 8'd1, 1'b0, 1'b0);

    send(16'h3F80, 16'h4000, 1'b0, 1'b1);
    send(16'h4040, 16'h3F80, 1'b0, 1'b1);
    send(16'h4000, 16'h4000, 1'b0, 1'b1);
    check("b2b_1_now", 32'(out_valid_44), 32'h1);
    get_result("b2b_1", 16'h4000, 8'd1, 1'b0, 1'b0);
    check("b2b_2_now", 32'(out_valid_44), 32'h1);
    get_result("b2b_2", 16'h4040, 8'd1, 1'b0, 1'b0);
    check("b2b_3_now", 32'(out_valid_44), 32'h1);
    get_result("b2b_3", 16'h4080, 8'd1, 1'b0, 1'b0);

    // Backpressure: three 1-beat vectors while the consumer stalls
    out_ready_44 = 1'b0;
    send(16'h3F80, 16'h3F80, 1'b0, 1'b1);
    send(16'h4000, 16'h3F80, 1'b0, 1'b1);
    send(16'h4040, 16'h3F80, 1'b0, 1'b1);
    repeat (4) tick();
    check("bp_in_ready", 32'(in_ready_44),   32'h0);
    check("bp_valid",    32'(out_valid_44),  32'h1);
    check("bp_result",   32'(out_result_44), 32'h3F80);
    check("bp_count",    32'(out_count_44),  32'h1);
    out_ready_44 = 1'b1;
    tick();
    check("bp_2_now", 32'(out_valid_44), 32'h1);
    get_result("bp_2", 16'h4000, 8'd1, 1'b0, 1'b0);
    check("bp_3_now", 32'(out_valid_44), 32'h1);
    get_result("bp_3", 16'h4040, 8'd1, 1'b0, 1'b0);
    check("bp_no_dup", 32'(out_valid_44), 32'h0);

    // Reset between edges while a result is presented and a vector is partial
    send(16'h4040, 16'h3F80, 1'b0, 1'b1);
    send(16'h3F80, 16'h3F80, 1'b0, 1'b0);
    send(16'h3F80, 16'h3F80, 1'b0, 1'b0);
    check("mid_pre_valid", 32'(out_valid_44), 32'h1);
    #3;
    rst_44 = 1'b1;
    #1;
    check("mid_rst_valid",   32'(out_valid_44),   32'h0);
    check("mid_rst_result",  32'(out_result_44),  32'h0);
    check("mid_rst_count",   32'(out_count_44),   32'h0);
    check("mid_rst_special", 32'(out_special_44), 32'h0);
    check("mid_rst_ovf",     32'(out_ovf_44),     32'h0);
    tick();
    rst_44 = 1'b0;
    tick();
    send(16'h4000, 16'h3F80, 1'b0, 1'b1);
    get_result("post_rst", 16'h4000, 8'd1, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) send(16'h3F80, 16'h3F80, 1'b0, i == 299);
    get_result("count_sat", 16'h4396, 8'd255, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
